// File: rtl/mdu_if.sv
// Request/response bundle between execute-stage control and the multiply/divide sequencer.
// The master issues the operation; the slave returns busy/done and the result.
interface mdu_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, funct3, src_a, src_b,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, src_a, src_b,
    output busy, done, result
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with single-cycle shortcuts for divide-by-zero and signed overflow.
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  mdu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   MIN_W   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]   ONES_W  = {WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   opnd_reg, opnd_next;
  logic [2:0]         f3_reg, f3_next;
  logic               sa_reg, sa_next;
  logic               sb_reg, sb_next;
  logic [WIDTH-1:0]   result_reg, result_next;

  // Request decode, evaluated on the incoming operands while idle.
  logic             in_div, in_sa, in_sb, in_bzero, in_ovf;
  logic [WIDTH-1:0] in_mag_a, in_mag_b, in_fast_res;

  always_comb begin
    in_div   = bus.funct3[2];
    in_sa    = bus.src_a[WIDTH-1] &
               ((bus.funct3 == 3'b001) | (bus.funct3 == 3'b010) |
                (bus.funct3 == 3'b100) | (bus.funct3 == 3'b110));
    in_sb    = bus.src_b[WIDTH-1] &
               ((bus.funct3 == 3'b001) | (bus.funct3 == 3'b100) | (bus.funct3 == 3'b110));
    in_mag_a = in_sa ? (~bus.src_a + ONE_W) : bus.src_a;
    in_mag_b = in_sb ? (~bus.src_b + ONE_W) : bus.src_b;
    in_bzero = in_div & (bus.src_b == '0);
    in_ovf   = in_div & ~bus.funct3[0] & (bus.src_a == MIN_W) & (bus.src_b == ONES_W);
    if (in_bzero) begin
      in_fast_res = bus.funct3[1] ? bus.src_a : ONES_W;
    end else begin
      in_fast_res = bus.funct3[1] ? '0 : MIN_W;
    end
  end

  // One iteration of the datapath; which half applies depends on the latched operation.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    div_trial = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opnd_reg};
    // The trial value is below 2*divisor, so the borrow bit alone says whether it fits.
    div_ge    = ~div_diff[WIDTH];
    if (f3_reg[2]) begin
      acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                  acc_reg[WIDTH-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc_reg[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   quot_fin, rem_fin, final_res;

  always_comb begin
    prod_fin = (sa_reg ^ sb_reg) ? (~acc_step + ONE_2W) : acc_step;
    quot_fin = (sa_reg ^ sb_reg) ? (~acc_step[WIDTH-1:0] + ONE_W) : acc_step[WIDTH-1:0];
    rem_fin  = sa_reg ? (~acc_step[2*WIDTH-1:WIDTH] + ONE_W) : acc_step[2*WIDTH-1:WIDTH];
    case (f3_reg)
      3'b000:                 final_res = prod_fin[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fin[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         final_res = quot_fin;
      default:                final_res = rem_fin;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    opnd_next   = opnd_reg;
    f3_next     = f3_reg;
    sa_next     = sa_reg;
    sb_next     = sb_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          f3_next   = bus.funct3;
          sa_next   = in_sa;
          sb_next   = in_sb;
          // Multiply keeps the multiplicand aside and shifts the multiplier through
          // the low half; divide keeps the divisor aside and shifts the dividend.
          opnd_next = in_div ? in_mag_b : in_mag_a;
          acc_next  = {{WIDTH{1'b0}}, (in_div ? in_mag_a : in_mag_b)};
          cnt_next  = '0;
          if (in_bzero | in_ovf) begin
            result_next = in_fast_res;
            state_next  = DONE;
          end else begin
            state_next  = CALC;
          end
        end
      end
      CALC: begin
        acc_next = acc_step;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(WIDTH - 1)) begin
          cnt_next    = '0;
          result_next = final_res;
          state_next  = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      f3_reg     <= '0;
      sa_reg     <= 1'b0;
      sb_reg     <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      opnd_reg   <= opnd_next;
      f3_reg     <= f3_next;
      sa_reg     <= sa_next;
      sb_reg     <= sb_next;
      result_reg <= result_next;
    end
  end

  assign bus.busy   = (state_reg != IDLE);
  assign bus.done   = (state_reg == DONE);
  assign bus.result = result_reg;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: hand-computed RV32M results, cycle timing,
// busy-time start rejection, back-to-back acceptance and mid-operation reset.
module tb_mdu_sequencer;
  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   cyc;

  mdu_if #(.WIDTH(WIDTH)) bus ();

  mdu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation in the current cycle (cycle 0) and follow it to completion.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_cyc, input string tag);
    int   done_cyc;
    logic busy_ok;
    done_cyc = -1;
    busy_ok  = 1'b1;
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.src_a  = a;
    bus.src_b  = b;
    tick();
    bus.start  = 1'b0;
    bus.funct3 = ~f;
    bus.src_a  = ~a;
    bus.src_b  = ~b;
    for (int c = 1; c <= WIDTH + 4; c++) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    check({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
    check({tag, " busy_through_done"}, {63'd0, busy_ok}, 64'd1);
    check({tag, " result"}, {32'd0, bus.result}, {32'd0, exp_res});
    tick();
    check({tag, " busy_after"}, {63'd0, bus.busy}, 64'd0);
    check({tag, " done_after"}, {63'd0, bus.done}, 64'd0);
    check({tag, " result_held"}, {32'd0, bus.result}, {32'd0, exp_res});
    $display("op %s: f3=%0d a=%h b=%h exp=%h got=%h done_cycle=%0d",
             tag, f, a, b, exp_res, bus.result, done_cyc);
  endtask

  initial begin
    int n_done;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.src_a  = '0;
    bus.src_b  = '0;
    tick();
    tick();
    check("reset busy", {63'd0, bus.busy}, 64'd0);
    check("reset done", {63'd0, bus.done}, 64'd0);
    check("reset result", {32'd0, bus.result}, 64'd0);
    rst = 1'b0;
    tick();

    run_op(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MUL 7*-3");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "MULH min*min");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU max*max");
    run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33, "MULHSU -1*2");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, "DIV -7/2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, "REM -7/2");
    run_op(3'b101, 32'd100,      32'd7,        32'd14,        33, "DIVU 100/7");
    run_op(3'b111, 32'd100,      32'd7,        32'd2,         33, "REMU 100/7");
    run_op(3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1,  "DIVU 5/0");
    run_op(3'b110, 32'd5,        32'd0,        32'd5,         1,  "REM 5/0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1, "REM ovf");

    // Starts during CALC and DONE are ignored; a start held into the following IDLE cycle is taken.
    cyc = 0;
    n_done = 0;
    bus.start  = 1'b1;
    bus.funct3 = 3'b000;
    bus.src_a  = 32'd7;
    bus.src_b  = 32'hFFFF_FFFD;
    tick();
    bus.start = 1'b0;
    while (cyc <= 68) begin
      if (bus.done === 1'b1 && cyc != 33 && cyc != 67) n_done++;
      if (cyc == 5) begin
        bus.start  = 1'b1;
        bus.funct3 = 3'b101;
        bus.src_a  = 32'd100;
        bus.src_b  = 32'd7;
      end else if (cyc == 6) begin
        bus.start = 1'b0;
        check("busy ignore cyc6 busy", {63'd0, bus.busy}, 64'd1);
      end else if (cyc == 33) begin
        check("b2b first done", {63'd0, bus.done}, 64'd1);
        check("b2b first result", {32'd0, bus.result}, 64'h0000_0000_FFFF_FFEB);
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.src_a  = 32'd3;
        bus.src_b  = 32'd4;
      end else if (cyc == 34) begin
        check("b2b idle busy", {63'd0, bus.busy}, 64'd0);
        check("b2b idle result", {32'd0, bus.result}, 64'h0000_0000_FFFF_FFEB);
      end else if (cyc == 35) begin
        bus.start = 1'b0;
        check("b2b second busy", {63'd0, bus.busy}, 64'd1);
      end else if (cyc == 67) begin
        check("b2b second done", {63'd0, bus.done}, 64'd1);
        check("b2b second result", {32'd0, bus.result}, 64'd12);
      end
      tick();
    end
    check("b2b stray done pulses", 64'(n_done), 64'd0);
    $display("op busy/b2b: first=FFFFFFEB@33 second=12@67 stray_done=%0d", n_done);

    // Reset in the middle of an iterative operation abandons it.
    cyc = 0;
    n_done = 0;
    bus.start  = 1'b1;
    bus.funct3 = 3'b000;
    bus.src_a  = 32'd7;
    bus.src_b  = 32'd9;
    tick();
    bus.start = 1'b0;
    while (cyc < 10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst busy", {63'd0, bus.busy}, 64'd0);
    check("midrst done", {63'd0, bus.done}, 64'd0);
    check("midrst result", {32'd0, bus.result}, 64'd0);
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) n_done++;
      tick();
    end
    check("midrst no done", 64'(n_done), 64'd0);
    $display("op midreset: busy=%0b done=%0b result=%h later_done=%0d",
             bus.busy, bus.done, bus.result, n_done);
    run_op(3'b000, 32'd3, 32'd4, 32'd12, 33, "MUL 3*4 after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Iterative multiply/divide sequencer for the RV32M extension. It sits beside the main ALU in the execute stage. When `alu_op`/`funct7` decode an M-type instruction, control raises `start_i`. The block runs a WIDTH-cycle shift-add / restoring-divide loop and holds `busy_o` high so the hazard logic stalls the pipeline until `done_o`.

## Interface
- `WIDTH`, default 32: operand/result width. Sets the iteration count. Must be ≥ 4.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: request an operation. Sampled only in IDLE.
- `funct3_i` in 3: operation select.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `src_a_i` in WIDTH: rs1 operand (multiplicand/dividend). Sampled with `start_i`.
- `src_b_i` in WIDTH: rs2 operand (multiplier/divisor). Sampled with `start_i`.
- `busy_o` out 1: high from the cycle after acceptance through the DONE cycle inclusive.
- `done_o` out 1: single-cycle pulse; `result_o` is valid in that cycle.
- `result_o` out WIDTH: registered result. Held from DONE until the next accepted start.

## Operation
- States are IDLE, CALC and DONE. A 5-bit (clog2 WIDTH) iteration counter is used in CALC.
- **IDLE, `start_i`=1:**
  - Latch `funct3`.
  - Record operand signs:
    - `sa` = a[MSB] for MULH/MULHSU/DIV/REM, else 0.
    - `sb` = b[MSB] for MULH/DIV/REM, else 0.
  - Latch magnitudes |a| and |b| (two's-complement negate when the sign is set).
  - Clear the 2·WIDTH accumulator and set the counter to 0.
  - Go to CALC, except for the fast paths below.
- **Fast paths (divide only), IDLE → DONE directly:**
  - b == 0: quotient = all ones; remainder = a, unmodified.
  - DIV/REM with a = 0x80..0 and b = all ones: quotient = 0x80..0; remainder = 0.
- **CALC, multiply:** each cycle, if the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator. Then shift the accumulator/multiplier right by 1, keeping the carry-out as the new MSB.
- **CALC, divide:** each cycle, shift {rem, quot} left by 1. Trial-subtract |b| from rem. If the result is non-negative, keep it and set quot LSB = 1, otherwise restore.
- **End of CALC:** after exactly WIDTH CALC cycles, go to DONE and register `result_o` on that same edge:
  - MUL: low WIDTH bits of the product, negated (2·WIDTH-wide negate) if `sa`^`sb`.
  - MULH/MULHSU/MULHU: high WIDTH bits of the product, with the same negation rule.
  - DIV/DIVU: quotient, negated if `sa`^`sb`.
  - REM/REMU: remainder, negated if `sa`.
- **DONE:** `done_o`=1 for one cycle, then unconditionally to IDLE. `start_i` is ignored in CALC and DONE.
- **Reset (any state, including mid-CALC):** state=IDLE, counter=0, `busy_o`=0, `done_o`=0, `result_o`=0, accumulator cleared. The operation in flight is abandoned with no `done_o`.

## Timing
- Cycle 0 is the cycle in which IDLE samples `start_i`=1.
- Iterative path:
  - `busy_o`=1 in cycles 1..WIDTH+1.
  - `done_o`=1 in cycle WIDTH+1 only (33 for WIDTH=32).
  - IDLE again in cycle WIDTH+2, so the earliest next acceptance is cycle WIDTH+2.
- Fast path: `busy_o`=1 and `done_o`=1 in cycle 1; IDLE in cycle 2.
- Operands may change after cycle 0 without affecting the result.
- If `start_i` is still high in the IDLE cycle after DONE, it is a new request and is accepted. The pipeline must drop `start_i` once it observes `done_o`.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Signed multiply:** MUL with a=7, b=0xFFFFFFFD (−3).
  - `result_o`=0xFFFFFFEB with `done_o` in cycle 33.
  - `busy_o` high in cycles 1–33.
- **High-word multiply:**
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- **Signed divide/remainder:**
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - All with `done_o` in cycle 33.
- **Fast paths:**
  - DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, with `done_o` in cycle 1.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0. Both with `done_o` in cycle 1.
- **Busy handling:** pulse `start_i` with different operands in cycles 5 and 33.
  - Both pulses are ignored and the first result is unchanged.
  - Back-to-back: a start held into cycle 34 is accepted, giving a second `done_o` in cycle 67.
- **Reset mid-CALC:** assert `rst_i` in cycle 10.
  - Next cycle: `busy_o`=0, `done_o`=0, `result_o`=0, and no `done_o` ever appears.
  - A new MUL 3×4 then returns 12 after 33 cycles.
